pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS core, and the successor to the fixed-width, fixed-vector PC register. It produces the fetch address every cycle. Supported actions are sequential increment, external jump/branch load, stall, a per-program boot vector table, and single-level interrupt entry/return with saved EPC. It sits between the next-address logic and instruction memory.

---
 rtl/mips_pkg.sv | 18 +
 rtl/irq_edge_latch.sv | 32 +++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS fetch front end.
// Holds the PC sequencer state encoding and reset-time vector defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_ISR  = 2'b10
    } pc_state_e;

    localparam int unsigned IRQ_VECTOR_DEF = 8;

    // Entry 3 in the top word, entry 0 in the bottom word.
    localparam logic [127:0] BOOT_VECTORS_DEF = {
        32'd35, 32'd0, 32'd25, 32'd0
    };

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector with a sticky pending flag for the interrupt line.
// pending_o includes a same-cycle rise so the sequencer can act without delay.
module irq_edge_latch
    import mips_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic interrupt,
    input  logic clear,
    output logic pending_o
);

    logic irq_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise      = interrupt & ~irq_q;
    assign pending_o = pend_q | rise;
    assign pend_d    = clear ? 1'b0 : (pend_q | rise);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            irq_q  <= interrupt;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot vectors, increment, load, stall,
// and single-level interrupt entry/return with a saved EPC.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STEP       = 1,
    parameter int unsigned PROG_SEL_W = 2,
    parameter logic [(2**PROG_SEL_W)*WIDTH-1:0] BOOT_VECTORS =
        BOOT_VECTORS_DEF,
    parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(IRQ_VECTOR_DEF)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PROG_SEL_W-1:0] progr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_addr,
    input  logic                  interrupt,
    input  logic                  eret,
    output logic [WIDTH-1:0]      programCounter,
    output logic [WIDTH-1:0]      epc,
    output logic                  in_isr
);

    localparam int unsigned NUM_PROGS = 2**PROG_SEL_W;

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             reent_q, reent_d;
    logic             irq;
    logic             clr;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] boot_tbl [NUM_PROGS];

    for (genvar i = 0; i < NUM_PROGS; i++) begin : g_boot
        assign boot_tbl[i] = BOOT_VECTORS[i*WIDTH +: WIDTH];
    end

    irq_edge_latch u_irq (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .clear     (clr),
        .pending_o (irq)
    );

    assign pc_inc = pc_q + WIDTH'(STEP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        reent_d = reent_q;
        clr     = 1'b0;
        if (enable) begin
            reent_d = 1'b0;
            case (state_q)
                ST_BOOT: begin
                    pc_d    = boot_tbl[progr];
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (irq) begin
                        // Right after eret the returned PC is not yet executed.
                        if (load)         epc_d = load_addr;
                        else if (reent_q) epc_d = pc_q;
                        else              epc_d = pc_inc;
                        pc_d    = IRQ_VECTOR;
                        state_d = ST_ISR;
                        clr     = 1'b1;
                    end else if (load) begin
                        pc_d = load_addr;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                ST_ISR: begin
                    if (eret) begin
                        pc_d    = epc_q;
                        state_d = ST_RUN;
                        reent_d = irq;
                    end else if (load) begin
                        pc_d = load_addr;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            epc_q   <= '0;
            reent_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            reent_q <= reent_d;
        end
    end

    assign programCounter = pc_q;
    assign epc            = epc_q;
    assign in_isr         = (state_q == ST_ISR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, load, interrupt entry/return,
// stall behaviour, wrap-around and asynchronous reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rstn, en, ld, irq, er;
    logic [1:0]  progr;
    logic [31:0] la;
    logic [31:0] pc, epc;
    logic        isr;

    logic        rstn8, en8, ld8, irq8, er8;
    logic [1:0]  progr8;
    logic [7:0]  la8;
    logic [7:0]  pc8, epc8;
    logic        isr8;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clock          (clk),
        .reset          (rstn),
        .enable         (en),
        .progr          (progr),
        .load           (ld),
        .load_addr      (la),
        .interrupt      (irq),
        .eret           (er),
        .programCounter (pc),
        .epc            (epc),
        .in_isr         (isr)
    );

    pc_sequencer #(
        .WIDTH        (8),
        .BOOT_VECTORS ({8'd35, 8'd0, 8'd25, 8'd0})
    ) u_dut8 (
        .clock          (clk),
        .reset          (rstn8),
        .enable         (en8),
        .progr          (progr8),
        .load           (ld8),
        .load_addr      (la8),
        .interrupt      (irq8),
        .eret           (er8),
        .programCounter (pc8),
        .epc            (epc8),
        .in_isr         (isr8)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; ld = 1'b0; irq = 1'b0; er = 1'b0;
        progr = 2'd0; la = '0;
        rstn8 = 1'b0; en8 = 1'b0; ld8 = 1'b0; irq8 = 1'b0; er8 = 1'b0;
        progr8 = 2'd0; la8 = '0;

        #3;
        check("rst_pc", pc, 0);
        check("rst_epc", epc, 0);
        check("rst_isr", {31'd0, isr}, 0);

        // Boot program 1
        tick();
        rstn = 1'b1; en = 1'b1; progr = 2'd1;
        tick(); check("boot1", pc, 25);
        tick(); check("inc26", pc, 26);
        tick(); check("inc27", pc, 27);

        // Interrupt entry and return from PC=40
        ld = 1'b1; la = 32'd40;
        tick(); check("ld40", pc, 40);
        ld = 1'b0; irq = 1'b1;
        tick(); check("irq_pc", pc, 8);
        check("irq_epc", epc, 41);
        check("irq_isr", {31'd0, isr}, 1);
        irq = 1'b0;
        tick(); check("isr9", pc, 9);
        tick(); check("isr10", pc, 10);
        er = 1'b1;
        tick(); check("eret_pc", pc, 41);
        check("eret_isr", {31'd0, isr}, 0);
        er = 1'b0;

        // Edge during ISR re-enters after eret
        tick(); check("run42", pc, 42);
        irq = 1'b1;
        tick(); check("irq2_pc", pc, 8);
        check("irq2_epc", epc, 43);
        irq = 1'b0;
        tick(); check("isr9b", pc, 9);
        irq = 1'b1;
        tick(); check("isr10b", pc, 10);
        check("isr_epc_hold", epc, 43);
        irq = 1'b0; er = 1'b1;
        tick(); check("ret43", pc, 43);
        check("ret43_isr", {31'd0, isr}, 0);
        er = 1'b0;
        tick(); check("reent_pc", pc, 8);
        check("reent_epc", epc, 43);
        check("reent_isr", {31'd0, isr}, 1);
        er = 1'b1;
        tick(); check("ret43b", pc, 43);
        er = 1'b0;

        // Load and interrupt in the same cycle
        ld = 1'b1; la = 32'd200; irq = 1'b1;
        tick(); check("ldirq_pc", pc, 8);
        check("ldirq_epc", epc, 200);
        ld = 1'b0; irq = 1'b0; er = 1'b1;
        tick(); check("ret200", pc, 200);
        er = 1'b0;

        // Stall with an interrupt pulse inside
        en = 1'b0;
        tick(); check("stall1_pc", pc, 200);
        irq = 1'b1;
        tick(); check("stall2_pc", pc, 200);
        check("stall2_epc", epc, 200);
        check("stall2_isr", {31'd0, isr}, 0);
        irq = 1'b0;
        tick(); check("stall3_pc", pc, 200);
        en = 1'b1;
        tick(); check("stirq_pc", pc, 8);
        check("stirq_epc", epc, 201);
        er = 1'b1;
        tick(); check("ret201", pc, 201);
        er = 1'b0;

        // Re-boot into program 3 with a load on cycle 3
        rstn = 1'b0;
        #1;
        check("rst2_pc", pc, 0);
        check("rst2_epc", epc, 0);
        progr = 2'd3;
        #2 rstn = 1'b1;
        tick(); check("boot3", pc, 35);
        tick(); check("inc36", pc, 36);
        ld = 1'b1; la = 32'd100;
        tick(); check("ld100", pc, 100);
        ld = 1'b0;
        tick(); check("inc101", pc, 101);

        // 8-bit instance: wrap-around and async reset inside ISR
        en = 1'b0;
        rstn8 = 1'b1; en8 = 1'b1; progr8 = 2'd0;
        tick(); check("w8_boot", {24'd0, pc8}, 0);
        ld8 = 1'b1; la8 = 8'd255;
        tick(); check("w8_ld255", {24'd0, pc8}, 255);
        ld8 = 1'b0;
        tick(); check("w8_wrap", {24'd0, pc8}, 0);
        irq8 = 1'b1;
        tick(); check("w8_irq", {24'd0, pc8}, 8);
        check("w8_epc", {24'd0, epc8}, 1);
        check("w8_isr", {31'd0, isr8}, 1);
        irq8 = 1'b0;
        tick();
        irq8 = 1'b1;
        tick(); check("w8_isr10", {24'd0, pc8}, 10);
        irq8 = 1'b0;
        #3 rstn8 = 1'b0;
        #1;
        check("w8_arst_pc", {24'd0, pc8}, 0);
        check("w8_arst_epc", {24'd0, epc8}, 0);
        check("w8_arst_isr", {31'd0, isr8}, 0);
        progr8 = 2'd1;
        #2 rstn8 = 1'b1;
        tick(); check("w8_reboot", {24'd0, pc8}, 25);
        tick(); check("w8_nopend", {24'd0, pc8}, 26);
        check("w8_nopend_isr", {31'd0, isr8}, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
